// File: rtl/serial_pkg.sv
// Types and constants shared by the serial word feeder and the shift-register wrapper.
package serial_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } feeder_state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/serial_word_feeder.sv
// Serialises one WIDTH-bit word per handshake into a bidirectional shift register,
// ordering bits so the word sits aligned in the register after the last shift.
module serial_word_feeder
  import serial_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_dir,
  input  logic             abort,
  output logic             sr_d,
  output logic             sr_en,
  output logic             sr_dir,
  output logic             word_done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

  feeder_state_t    state_r;
  logic [WIDTH-1:0] shift_buf_r;
  logic [CNT_W-1:0] bit_cnt_r;
  logic [GAP_W-1:0] gap_cnt_r;

  function automatic logic lead_bit(input logic [WIDTH-1:0] w, input logic dir);
    return (dir == DIR_RIGHT) ? w[0] : w[WIDTH-1];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w, input logic dir);
    return (dir == DIR_RIGHT) ? {1'b0, w[WIDTH-1:1]} : {w[WIDTH-2:0], 1'b0};
  endfunction

  assign in_ready = (state_r == ST_IDLE);

  // Feeder FSM with registered serial outputs; bit_cnt_r counts bits already presented.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= ST_IDLE;
      shift_buf_r <= {WIDTH{1'b0}};
      bit_cnt_r   <= {CNT_W{1'b0}};
      gap_cnt_r   <= {GAP_W{1'b0}};
      sr_d        <= 1'b0;
      sr_en       <= 1'b0;
      sr_dir      <= 1'b0;
      word_done   <= 1'b0;
    end else begin
      word_done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (in_valid) begin
            state_r     <= ST_SHIFT;
            sr_dir      <= in_dir;
            sr_d        <= lead_bit(in_data, in_dir);
            sr_en       <= 1'b1;
            shift_buf_r <= advance(in_data, in_dir);
            bit_cnt_r   <= CNT_W'(1);
          end
        end
        ST_SHIFT: begin
          // The last bit cycle completes regardless of abort.
          if ((bit_cnt_r == LAST_BIT) || abort) begin
            sr_en     <= 1'b0;
            sr_d      <= 1'b0;
            word_done <= (bit_cnt_r == LAST_BIT);
            bit_cnt_r <= {CNT_W{1'b0}};
            gap_cnt_r <= {GAP_W{1'b0}};
            if (GAP > 0) begin
              state_r <= ST_GAP;
            end else begin
              state_r <= ST_IDLE;
            end
          end else begin
            sr_d        <= lead_bit(shift_buf_r, sr_dir);
            shift_buf_r <= advance(shift_buf_r, sr_dir);
            bit_cnt_r   <= bit_cnt_r + CNT_W'(1);
          end
        end
        ST_GAP: begin
          if (gap_cnt_r == GAP_LAST) begin
            gap_cnt_r <= {GAP_W{1'b0}};
            state_r   <= ST_IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r + GAP_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          sr_en   <= 1'b0;
          sr_d    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_word_feeder.sv
// Bench: two feeders (GAP=1 and GAP=0) on shared stimulus, checked every cycle against a
// cycle-indexed word model, plus hand-computed directed expectations.
module tb_serial_word_feeder;

  localparam int W = 8;

  logic       clk = 1'b0;
  logic       rstn;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_dir;
  logic       abort;
  logic [1:0] rdy_v, d_v, en_v, dir_v, wd_v;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0] ds [2];

  // model state per instance: active word, handshake cycle, word, dir, abort bit index
  logic       m_act  [2];
  int         m_k    [2];
  logic [7:0] m_word [2];
  logic       m_dir  [2];
  int         m_abj  [2];
  logic       m_ldir [2];

  serial_word_feeder #(.WIDTH(W), .GAP(1)) u_gap1 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(rdy_v[0]),
    .in_data(in_data), .in_dir(in_dir), .abort(abort),
    .sr_d(d_v[0]), .sr_en(en_v[0]), .sr_dir(dir_v[0]), .word_done(wd_v[0])
  );

  serial_word_feeder #(.WIDTH(W), .GAP(0)) u_gap0 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(rdy_v[1]),
    .in_data(in_data), .in_dir(in_dir), .abort(abort),
    .sr_d(d_v[1]), .sr_en(en_v[1]), .sr_dir(dir_v[1]), .word_done(wd_v[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // downstream bidirectional shift registers fed by each feeder
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (en_v[i]) begin
        if (dir_v[i]) ds[i] <= {d_v[i], ds[i][7:1]};
        else          ds[i] <= {ds[i][6:0], d_v[i]};
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // compare process: expected outputs of cycle c follow from the handshake cycle k and j = c-k
  always @(negedge clk) begin
    int j, end_j, gap;
    logic e_en, e_d, e_wd, e_rdy;
    for (int i = 0; i < 2; i++) begin
      gap = (i == 0) ? 1 : 0;
      if (!rstn) begin
        m_act[i] = 1'b0; m_abj[i] = 0; m_ldir[i] = 1'b0; m_k[i] = 0;
        chk("rst_ready", 32'(rdy_v[i]), 32'd1);
        chk("rst_en",    32'(en_v[i]),  32'd0);
        chk("rst_d",     32'(d_v[i]),   32'd0);
        chk("rst_done",  32'(wd_v[i]),  32'd0);
        chk("rst_dir",   32'(dir_v[i]), 32'd0);
      end else begin
        j = cyc - m_k[i];
        if (m_act[i]) begin
          end_j = (m_abj[i] != 0) ? m_abj[i] : W;
          e_en  = (j >= 1) && (j <= end_j);
          e_d   = e_en ? (m_dir[i] ? m_word[i][j-1] : m_word[i][W-j]) : 1'b0;
          e_wd  = (m_abj[i] == 0) && (j == W + 1);
          e_rdy = (j >= end_j + 1 + gap);
        end else begin
          e_en = 1'b0; e_d = 1'b0; e_wd = 1'b0; e_rdy = 1'b1;
        end
        chk(i == 0 ? "g1_ready" : "g0_ready", 32'(rdy_v[i]), 32'(e_rdy));
        chk(i == 0 ? "g1_en"    : "g0_en",    32'(en_v[i]),  32'(e_en));
        chk(i == 0 ? "g1_d"     : "g0_d",     32'(d_v[i]),   32'(e_d));
        chk(i == 0 ? "g1_done"  : "g0_done",  32'(wd_v[i]),  32'(e_wd));
        chk(i == 0 ? "g1_dir"   : "g0_dir",   32'(dir_v[i]), 32'(m_ldir[i]));
        if (e_wd) chk(i == 0 ? "g1_reg" : "g0_reg", 32'(ds[i]), 32'(m_word[i]));
        if (e_rdy && in_valid) begin
          m_act[i] = 1'b1; m_k[i] = cyc; m_word[i] = in_data;
          m_dir[i] = in_dir; m_ldir[i] = in_dir; m_abj[i] = 0;
        end else if (m_act[i] && abort && m_abj[i] == 0 && j >= 1 && j <= W - 1) begin
          m_abj[i] = j;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present a word until the GAP=1 feeder takes it; returns the handshake cycle
  task automatic send(input logic [7:0] w, input logic d, input logic hold, output int k);
    int guard;
    guard = 0;
    in_valid = 1'b1; in_data = w; in_dir = d;
    while (!rdy_v[0] && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) chk("handshake_timeout", 32'(guard), 32'd0);
    k = cyc;
    tick();
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic collect(output logic [7:0] bits, output int ens, output logic dir_all);
    bits = 8'h00; ens = 0; dir_all = 1'b1;
    for (int t = 1; t <= W; t++) begin
      @(negedge clk);
      bits = {bits[6:0], d_v[0]};
      ens += int'(en_v[0]);
      dir_all = dir_all & dir_v[0];
      tick();
    end
  endtask

  initial begin
    int k, ens;
    logic [7:0] bits;
    logic dir_all;
    rstn = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_dir = 1'b0; abort = 1'b0;
    ds[0] = 8'h00; ds[1] = 8'h00;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    tick();

    // A5 left: MSB first
    send(8'hA5, 1'b0, 1'b0, k);
    collect(bits, ens, dir_all);
    @(negedge clk);
    chk("a5_bits", 32'(bits), 32'h0000_00A5);
    chk("a5_en_cnt", 32'(ens), 32'd8);
    chk("a5_done_k9", 32'(wd_v[0]), 32'd1);
    chk("a5_reg", 32'(ds[0]), 32'h0000_00A5);
    tick();

    // 3C right: LSB first gives 0,0,1,1,1,1,0,0
    send(8'h3C, 1'b1, 1'b0, k);
    collect(bits, ens, dir_all);
    @(negedge clk);
    chk("3c_bits", 32'(bits), 32'h0000_003C);
    chk("3c_dir", 32'(dir_all), 32'd1);
    chk("3c_done", 32'(wd_v[0]), 32'd1);
    chk("3c_reg", 32'(ds[0]), 32'h0000_003C);
    tick();

    // back-to-back with in_valid held: 01 then 80
    send(8'h01, 1'b0, 1'b1, k);
    in_data = 8'h80;
    while (cyc < k + 9) tick();
    @(negedge clk);
    chk("hold_g1_en_k9", 32'(en_v[0]), 32'd0);
    chk("hold_g1_done_k9", 32'(wd_v[0]), 32'd1);
    chk("hold_g0_en_k9", 32'(en_v[1]), 32'd0);
    chk("hold_g0_ready_k9", 32'(rdy_v[1]), 32'd1);
    tick();
    @(negedge clk);
    chk("hold_g1_en_k10", 32'(en_v[0]), 32'd0);
    chk("hold_g1_ready_k10", 32'(rdy_v[0]), 32'd1);
    chk("hold_g0_en_k10", 32'(en_v[1]), 32'd1);
    chk("hold_g0_d_k10", 32'(d_v[1]), 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("hold_g1_en_k11", 32'(en_v[0]), 32'd1);
    chk("hold_g1_d_k11", 32'(d_v[0]), 32'd1);
    tick();

    // abort mid-word in k+3, then abort while idle is ignored
    send(8'hC3, 1'b0, 1'b0, k);
    while (cyc < k + 3) tick();
    abort = 1'b1;
    @(negedge clk);
    chk("abort_en_k3", 32'(en_v[0]), 32'd1);
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_en_k4", 32'(en_v[0]), 32'd0);
    chk("abort_ready_k4", 32'(rdy_v[0]), 32'd0);
    chk("abort_nodone_k4", 32'(wd_v[0]), 32'd0);
    tick();
    @(negedge clk);
    chk("abort_ready_k5", 32'(rdy_v[0]), 32'd1);
    abort = 1'b1;
    repeat (3) tick();
    abort = 1'b0;

    // abort on the last bit is too late; abort during the gap is ignored
    send(8'h96, 1'b1, 1'b0, k);
    while (cyc < k + 8) tick();
    abort = 1'b1;
    tick();
    @(negedge clk);
    chk("late_abort_done", 32'(wd_v[0]), 32'd1);
    chk("late_abort_reg", 32'(ds[0]), 32'h0000_0096);
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("late_abort_ready", 32'(rdy_v[0]), 32'd1);
    tick();

    // asynchronous reset mid-word
    send(8'h5A, 1'b0, 1'b0, k);
    while (cyc < k + 4) tick();
    #1 rstn = 1'b0;
    #1;
    chk("arst_en", 32'(en_v[0]), 32'd0);
    chk("arst_d", 32'(d_v[0]), 32'd0);
    chk("arst_done", 32'(wd_v[0]), 32'd0);
    chk("arst_ready", 32'(rdy_v[0]), 32'd1);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(rdy_v[0]), 32'd1);
    tick();
    send(8'hFF, 1'b0, 1'b0, k);
    collect(bits, ens, dir_all);
    @(negedge clk);
    chk("ff_bits", 32'(bits), 32'h0000_00FF);
    chk("ff_en_cnt", 32'(ens), 32'd8);
    chk("ff_done", 32'(wd_v[0]), 32'd1);
    chk("ff_reg", 32'(ds[0]), 32'h0000_00FF);

    repeat (4) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
